cpu_0_ocimem_monitor_ctrl: RTL and testbench
============================================

Name: cpu_0_ocimem_monitor_ctrl

Overview:
System-clock-side consumer of the JTAG debug module's decoded commands (jdo plus take_action/take_no_action strobes) for the on-chip memory (OCI RAM/monitor) path. It converts those strobes into single-word Avalon-style master reads and writes with address auto-increment. It returns MonDReg, monitor_ready and monitor_error to the debug module, which shifts them back to the host.

Parameters:
ADDR_W, 8, word-address width of the monitor memory port
TIMEOUT, 255, max cycles mem_waitrequest may stay high before abort (only with OCIMEM_TIMEOUT_EN)

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
jdo  in  38  JTAG debug data, valid in the cycle a strobe is high
take_action_ocimem_a  in  1  1-cycle strobe: load address / control
take_action_ocimem_b  in  1  1-cycle strobe: write word
take_no_action_ocimem_a  in  1  1-cycle strobe: read next word
mem_address  out  ADDR_W  word address to monitor memory
mem_read  out  1  read request, held until accepted
mem_write  out  1  write request, held until accepted
mem_writedata  out  32  write data
mem_readdata  in  32  read data, valid in the cycle mem_read is high and mem_waitrequest is low
mem_waitrequest  in  1  slave stall
MonDReg  out  32  monitor data register (last read or written word)
monitor_ready  out  1  1 = idle, last command complete
monitor_error  out  1  sticky error flag

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: mem_address=0, mem_read=0, mem_write=0, mem_writedata=0, MonDReg=0, monitor_ready=1, monitor_error=0, FSM=IDLE.
- Internal MonAReg[ADDR_W-1:0] drives mem_address.
- FSM states: IDLE, RD, WR.
- IDLE, take_action_ocimem_a:
  - MonAReg <= jdo[ADDR_W-1:0].
  - jdo[35]=1 clears monitor_error.
  - jdo[34]=1 starts a read at the new address: next cycle mem_read=1, monitor_ready=0, state RD.
  - Otherwise stay in IDLE.
- IDLE, take_action_ocimem_b: MonDReg <= jdo[31:0], mem_writedata <= jdo[31:0]. Next cycle mem_write=1, monitor_ready=0, state WR.
- IDLE, take_no_action_ocimem_a: read at the current MonAReg. Next cycle mem_read=1, monitor_ready=0, state RD.
- Strobe priority if several are high in one cycle: ocimem_a > ocimem_b > no_action_ocimem_a. Lower-priority strobes are dropped and monitor_error is set.
- RD: hold mem_read and mem_address while mem_waitrequest=1. On the first cycle with mem_waitrequest=0:
  - MonDReg <= mem_readdata.
  - mem_read <= 0.
  - MonAReg <= MonAReg+1.
  - monitor_ready <= 1, state IDLE.
- WR: same as RD, but de-asserts mem_write, increments MonAReg and does not update MonDReg.
- Zero-wait slave: strobe at cycle N, request visible N+1, monitor_ready high at N+2.
- Address wraps modulo 2^ADDR_W: all-ones +1 = 0, with no error.
- Any strobe while not IDLE is ignored and sets monitor_error. The in-flight transfer continues unaffected.
- monitor_error is sticky; it is cleared only by reset or by a take_action_ocimem_a with jdo[35]=1.
- mem_read and mem_write are never high together.
- Reset mid-transfer drops the request in the same edge and returns all outputs to their reset values.

Optional Feature:
OCIMEM_TIMEOUT_EN
- Defined:
  - An 8-bit-or-wider wait counter clears on entry to RD/WR and counts while mem_waitrequest=1.
  - When the count reaches TIMEOUT with waitrequest still high, the request is de-asserted and monitor_error <= 1.
  - monitor_ready <= 1, state IDLE; MonAReg and MonDReg are unchanged.
- Undefined: no counter; RD/WR wait indefinitely for mem_waitrequest=0.

Test Plan:
- Reset, then idle 5 cycles -> monitor_ready=1, monitor_error=0, mem_read=mem_write=0, MonDReg=0, mem_address=0.
- take_action_ocimem_a with jdo[7:0]=0x10, jdo[34]=1; slave zero-wait returns 0xDEADBEEF -> mem_read one cycle at address 0x10, MonDReg=0xDEADBEEF, mem_address=0x11, monitor_ready high 2 cycles after the strobe.
- take_action_ocimem_b with jdo[31:0]=0x12345678 at MonAReg=0xFF; waitrequest high 3 cycles -> mem_write held 4 cycles at 0xFF with data 0x12345678, then mem_address=0x00 (wrap), MonDReg=0x12345678.
- Three take_no_action_ocimem_a strobes, each after monitor_ready, from address 0x20 -> reads at 0x20, 0x21, 0x22; final mem_address=0x23.
- take_action_ocimem_b issued while RD is stalled -> write dropped, monitor_error=1, read completes normally; then take_action_ocimem_a with jdo[35]=1 -> monitor_error=0.
- With OCIMEM_TIMEOUT_EN and TIMEOUT=16, mem_waitrequest stuck high on a read -> mem_read drops after 16 stalled cycles, monitor_error=1, monitor_ready=1, MonAReg unchanged. Without the macro -> mem_read stays high for 100+ cycles.

Source files
------------

// File: rtl/cpu_0_ocimem_monitor_ctrl.sv
// rtl/cpu_0_ocimem_monitor_ctrl.sv - JTAG OCI memory monitor master; turns debug strobes into single-word reads/writes.
// Optional stall abort enabled by defining OCIMEM_TIMEOUT_EN.
module cpu_0_ocimem_monitor_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] mon_a_reg, mon_a_nx;
  logic [31:0]       mon_d_nx, wdata_nx;
  logic              read_nx, write_nx, ready_nx, error_nx;
  logic              any_strobe, multi_strobe;
  logic              unused_jdo;

  assign unused_jdo  = ^{jdo[37:36], jdo[33:32]};
  assign mem_address = mon_a_reg;

`ifdef OCIMEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
`endif

  assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign multi_strobe = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a)) |
                        (take_action_ocimem_b & take_no_action_ocimem_a);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      mon_a_reg     <= '0;
      MonDReg       <= '0;
      mem_writedata <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
`ifdef OCIMEM_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      state         <= state_nx;
      mon_a_reg     <= mon_a_nx;
      MonDReg       <= mon_d_nx;
      mem_writedata <= wdata_nx;
      mem_read      <= read_nx;
      mem_write     <= write_nx;
      monitor_ready <= ready_nx;
      monitor_error <= error_nx;
`ifdef OCIMEM_TIMEOUT_EN
      wait_cnt      <= wait_cnt_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    mon_a_nx = mon_a_reg;
    mon_d_nx = MonDReg;
    wdata_nx = mem_writedata;
    read_nx  = mem_read;
    write_nx = mem_write;
    ready_nx = monitor_ready;
    error_nx = monitor_error;
`ifdef OCIMEM_TIMEOUT_EN
    wait_cnt_nx = wait_cnt;
`endif
    case (state)
      IDLE: begin
`ifdef OCIMEM_TIMEOUT_EN
        wait_cnt_nx = '0;
`endif
        if (take_action_ocimem_a) begin
          mon_a_nx = jdo[ADDR_W-1:0];
          if (jdo[35]) error_nx = 1'b0;
          if (jdo[34]) begin
            read_nx  = 1'b1;
            ready_nx = 1'b0;
            state_nx = RD;
          end
        end else if (take_action_ocimem_b) begin
          mon_d_nx = jdo[31:0];
          wdata_nx = jdo[31:0];
          write_nx = 1'b1;
          ready_nx = 1'b0;
          state_nx = WR;
        end else if (take_no_action_ocimem_a) begin
          read_nx  = 1'b1;
          ready_nx = 1'b0;
          state_nx = RD;
        end
        // Dropped lower-priority strobes must be visible to the host.
        if (multi_strobe) error_nx = 1'b1;
      end
      RD, WR: begin
        if (any_strobe) error_nx = 1'b1;
        if (!mem_waitrequest) begin
          if (state == RD) mon_d_nx = mem_readdata;
          read_nx  = 1'b0;
          write_nx = 1'b0;
          mon_a_nx = mon_a_reg + 1'b1;
          ready_nx = 1'b1;
          state_nx = IDLE;
        end
`ifdef OCIMEM_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          read_nx  = 1'b0;
          write_nx = 1'b0;
          error_nx = 1'b1;
          ready_nx = 1'b1;
          state_nx = IDLE;
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_0_ocimem_monitor_ctrl.sv
// tb/tb_cpu_0_ocimem_monitor_ctrl.sv - self-checking bench: vector table, corner sequences, randomized model compare.
module tb_cpu_0_ocimem_monitor_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        act_a, act_b, noact_a;
  logic [7:0]  mem_address;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata, mem_readdata, MonDReg;
  logic        mem_waitrequest, monitor_ready, monitor_error;

  int total_cnt = 0;
  int pass_cnt  = 0;

  cpu_0_ocimem_monitor_ctrl #(.ADDR_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(act_a), .take_action_ocimem_b(act_b),
    .take_no_action_ocimem_a(noact_a),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest), .MonDReg(MonDReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        a, b, n;
    logic [37:0] jdo;
    logic        wr;
    logic [31:0] rdata;
    logic [7:0]  e_addr;
    logic        e_rd, e_wr;
    logic [31:0] e_wdata, e_dreg;
    logic        e_rdy, e_err;
  } vec_t;

  vec_t vecs[14];

  // reference model state
  logic [7:0]  m_addr;
  logic [31:0] m_dreg, m_wdata;
  logic        m_err, m_busy, m_isrd;
  int          m_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    act_a = 0; act_b = 0; noact_a = 0; jdo = '0;
  endtask

  function automatic vec_t mk(input logic a, b, n, input logic [37:0] j, input logic wr,
                              input logic [31:0] rd, input logic [7:0] ea, input logic er, ew,
                              input logic [31:0] ewd, ed, input logic erdy, eerr);
    vec_t v;
    v.a = a; v.b = b; v.n = n; v.jdo = j; v.wr = wr; v.rdata = rd;
    v.e_addr = ea; v.e_rd = er; v.e_wr = ew; v.e_wdata = ewd; v.e_dreg = ed;
    v.e_rdy = erdy; v.e_err = eerr;
    return v;
  endfunction

  task automatic model_reset();
    m_addr = 0; m_dreg = 0; m_wdata = 0; m_err = 0; m_busy = 0; m_isrd = 0; m_stall = 0;
  endtask

  task automatic model_step();
    int ns;
    ns = int'(act_a) + int'(act_b) + int'(noact_a);
    if (!m_busy) begin
      if (act_a) begin
        m_addr = jdo[7:0];
        if (jdo[35]) m_err = 0;
        if (jdo[34]) begin m_busy = 1; m_isrd = 1; m_stall = 0; end
      end else if (act_b) begin
        m_dreg = jdo[31:0]; m_wdata = jdo[31:0];
        m_busy = 1; m_isrd = 0; m_stall = 0;
      end else if (noact_a) begin
        m_busy = 1; m_isrd = 1; m_stall = 0;
      end
      if (ns > 1) m_err = 1;
    end else begin
      if (ns > 0) m_err = 1;
      if (!mem_waitrequest) begin
        if (m_isrd) m_dreg = mem_readdata;
        m_addr = m_addr + 8'd1;
        m_busy = 0;
      end else begin
        m_stall++;
`ifdef OCIMEM_TIMEOUT_EN
        if (m_stall == TO) begin m_busy = 0; m_err = 1; end
`endif
      end
    end
  endtask

  initial begin
    int n_hi;
    int stalls;
    idle_in();
    mem_waitrequest = 0;
    mem_readdata = '0;
    reset = 1;
    tick(); tick();
    reset = 0;
    repeat (5) tick();
    chk("rst_ready", 32'(monitor_ready), 32'd1);
    chk("rst_error", 32'(monitor_error), 32'd0);
    chk("rst_read",  32'(mem_read), 32'd0);
    chk("rst_write", 32'(mem_write), 32'd0);
    chk("rst_dreg",  MonDReg, 32'd0);
    chk("rst_addr",  32'(mem_address), 32'd0);

    //            a b n  jdo                          wr rdata         addr  rd wr wdata         dreg          rdy err
    vecs[0]  = mk(1,0,0, (38'd1<<34)|38'h10,          0, 32'h0,        8'h10,1,0,32'h0,        32'h0,        0,0);
    vecs[1]  = mk(0,0,0, 38'h0,                       0, 32'hDEADBEEF, 8'h11,0,0,32'h0,        32'hDEADBEEF, 1,0);
    vecs[2]  = mk(1,0,0, 38'hFF,                      0, 32'h0,        8'hFF,0,0,32'h0,        32'hDEADBEEF, 1,0);
    vecs[3]  = mk(0,1,0, 38'h12345678,                1, 32'h0,        8'hFF,0,1,32'h12345678, 32'h12345678, 0,0);
    vecs[4]  = mk(0,0,0, 38'h0,                       1, 32'h0,        8'hFF,0,1,32'h12345678, 32'h12345678, 0,0);
    vecs[5]  = mk(0,0,0, 38'h0,                       1, 32'h0,        8'hFF,0,1,32'h12345678, 32'h12345678, 0,0);
    vecs[6]  = mk(0,0,0, 38'h0,                       1, 32'h0,        8'hFF,0,1,32'h12345678, 32'h12345678, 0,0);
    vecs[7]  = mk(0,0,0, 38'h0,                       0, 32'h0,        8'h00,0,0,32'h12345678, 32'h12345678, 1,0);
    vecs[8]  = mk(1,0,0, (38'd1<<34)|38'h40,          1, 32'h0,        8'h40,1,0,32'h12345678, 32'h12345678, 0,0);
    vecs[9]  = mk(0,1,0, 38'hAAAA5555,                1, 32'h0,        8'h40,1,0,32'h12345678, 32'h12345678, 0,1);
    vecs[10] = mk(0,0,0, 38'h0,                       0, 32'h0BADF00D, 8'h41,0,0,32'h12345678, 32'h0BADF00D, 1,1);
    vecs[11] = mk(1,0,0, (38'd1<<35)|38'h20,          0, 32'h0,        8'h20,0,0,32'h12345678, 32'h0BADF00D, 1,0);
    vecs[12] = mk(1,1,0, 38'h05,                      0, 32'h0,        8'h05,0,0,32'h12345678, 32'h0BADF00D, 1,1);
    vecs[13] = mk(1,0,0, (38'd1<<35)|38'h20,          0, 32'h0,        8'h20,0,0,32'h12345678, 32'h0BADF00D, 1,0);

    for (int i = 0; i < 14; i++) begin
      act_a = vecs[i].a; act_b = vecs[i].b; noact_a = vecs[i].n; jdo = vecs[i].jdo;
      mem_waitrequest = vecs[i].wr; mem_readdata = vecs[i].rdata;
      tick();
      chk($sformatf("v%0d_addr", i),  32'(mem_address),   32'(vecs[i].e_addr));
      chk($sformatf("v%0d_read", i),  32'(mem_read),      32'(vecs[i].e_rd));
      chk($sformatf("v%0d_write", i), 32'(mem_write),     32'(vecs[i].e_wr));
      chk($sformatf("v%0d_wdata", i), mem_writedata,      vecs[i].e_wdata);
      chk($sformatf("v%0d_dreg", i),  MonDReg,            vecs[i].e_dreg);
      chk($sformatf("v%0d_ready", i), 32'(monitor_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_error", i), 32'(monitor_error), 32'(vecs[i].e_err));
    end
    idle_in();

    // three sequential next-word reads starting at 0x20
    for (int k = 0; k < 3; k++) begin
      noact_a = 1; mem_waitrequest = 1;
      tick();
      noact_a = 0;
      chk($sformatf("seq%0d_read", k), 32'(mem_read), 32'd1);
      chk($sformatf("seq%0d_addr", k), 32'(mem_address), 32'h20 + 32'(k));
      stalls = k;
      repeat (stalls) tick();
      mem_waitrequest = 0; mem_readdata = 32'hA000_0000 + 32'(k);
      tick();
      chk($sformatf("seq%0d_ready", k), 32'(monitor_ready), 32'd1);
      chk($sformatf("seq%0d_dreg", k), MonDReg, 32'hA000_0000 + 32'(k));
    end
    chk("seq_final_addr", 32'(mem_address), 32'h23);

    // reset in the middle of a stalled write
    act_b = 1; jdo = 38'hCAFEF00D; mem_waitrequest = 1;
    tick();
    idle_in();
    chk("mid_write", 32'(mem_write), 32'd1);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_write", 32'(mem_write), 32'd0);
    chk("mid_rst_wdata", mem_writedata, 32'd0);
    chk("mid_rst_dreg",  MonDReg, 32'd0);
    chk("mid_rst_ready", 32'(monitor_ready), 32'd1);
    chk("mid_rst_addr",  32'(mem_address), 32'd0);

    // read against a slave that never releases waitrequest
    act_a = 1; jdo = (38'd1 << 34) | 38'h30; mem_waitrequest = 1;
    tick();
    idle_in();
    n_hi = 0;
    while (mem_read && n_hi < 120) begin
      n_hi++;
      tick();
    end
`ifdef OCIMEM_TIMEOUT_EN
    chk("to_read_cycles", 32'(n_hi), 32'(TO));
    chk("to_read_low", 32'(mem_read), 32'd0);
    chk("to_error", 32'(monitor_error), 32'd1);
    chk("to_ready", 32'(monitor_ready), 32'd1);
    chk("to_addr", 32'(mem_address), 32'h30);
`else
    chk("stall_read_cycles", 32'(n_hi), 32'd120);
    chk("stall_read_high", 32'(mem_read), 32'd1);
    chk("stall_ready", 32'(monitor_ready), 32'd0);
`endif

    // randomized traffic against the reference model
    reset = 1; mem_waitrequest = 0;
    tick();
    reset = 0;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      act_a   = ($urandom_range(0, 9) == 0);
      act_b   = ($urandom_range(0, 9) == 0);
      noact_a = ($urandom_range(0, 7) == 0);
      jdo     = {6'($urandom), 32'($urandom)};
      jdo[35] = ($urandom_range(0, 3) == 0);
      mem_waitrequest = ($urandom_range(0, 2) == 0);
      mem_readdata    = $urandom;
      model_step();
      tick();
      chk("rnd_addr",  32'(mem_address), 32'(m_addr));
      chk("rnd_read",  32'(mem_read), 32'(m_busy && m_isrd));
      chk("rnd_write", 32'(mem_write), 32'(m_busy && !m_isrd));
      chk("rnd_wdata", mem_writedata, m_wdata);
      chk("rnd_dreg",  MonDReg, m_dreg);
      chk("rnd_ready", 32'(monitor_ready), 32'(!m_busy));
      chk("rnd_error", 32'(monitor_error), 32'(m_err));
    end
    idle_in();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
